// File: rtl/mux2_rr_arbiter_pkg.sv
// ============================================================================
// mux2_rr_arbiter_pkg : shared state encoding for the 2-way round-robin mux arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mux2_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  // Grant state for a given requester index.
  function automatic state_t grant_state(input logic src);
    return src ? ST_G1 : ST_G0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux2x1_bus.sv
// ============================================================================
// mux2x1_bus : DATA_W-bit dataflow 2:1 mux (sel=0 -> a, sel=1 -> b)
// Rev 1.0
// ============================================================================
`default_nettype none

module mux2x1_bus #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sel,
  output logic [DATA_W-1:0] y
);

  assign y = sel ? b : a;

endmodule

`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
// ============================================================================
// mux2_rr_arbiter : round-robin, burst-capped arbiter sharing one 2:1 mux
// between two valid/ready requesters, with a single-entry output register.
// Rev 1.0
// ============================================================================
`default_nettype none

module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i0_valid,
  input  logic [DATA_W-1:0] i0_data,
  output logic              i0_ready,
  input  logic              i1_valid,
  input  logic [DATA_W-1:0] i1_data,
  output logic              i1_ready,
  output logic              y_valid,
  output logic [DATA_W-1:0] y_data,
  output logic              y_src,
  input  logic              y_ready,
  output logic              s
);

  localparam int               CNT_W  = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CAP_M1 = CNT_W'(MAX_BURST - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               last_grant, last_nx;
  logic               y_free, acc0, acc1;
  logic [DATA_W-1:0]  mux_data;

  assign y_free   = !y_valid || y_ready;
  assign i0_ready = (state == ST_G0) && y_free;
  assign i1_ready = (state == ST_G1) && y_free;
  assign acc0     = i0_valid && i0_ready;
  assign acc1     = i1_valid && i1_ready;

  mux2x1_bus #(.DATA_W(DATA_W)) u_mux (
    .a   (i0_data),
    .b   (i1_data),
    .sel (s),
    .y   (mux_data)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last_grant;
    unique case (state)
      ST_IDLE: begin
        if (i0_valid && i1_valid) state_nx = grant_state(!last_grant);
        else if (i0_valid)        state_nx = ST_G0;
        else if (i1_valid)        state_nx = ST_G1;
      end
      ST_G0: begin
        // A valid drop ends the tenure even while the output is stalled.
        if (!i0_valid) begin
          state_nx = i1_valid ? ST_G1 : ST_IDLE;
          cnt_nx   = '0;
          last_nx  = 1'b0;
        end else if (acc0) begin
          if (cnt == CAP_M1) begin
            cnt_nx  = '0;
            last_nx = 1'b0;
            if (i1_valid) state_nx = ST_G1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      ST_G1: begin
        if (!i1_valid) begin
          state_nx = i0_valid ? ST_G0 : ST_IDLE;
          cnt_nx   = '0;
          last_nx  = 1'b1;
        end else if (acc1) begin
          if (cnt == CAP_M1) begin
            cnt_nx  = '0;
            last_nx = 1'b1;
            if (i0_valid) state_nx = ST_G0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      s          <= 1'b0;
      y_valid    <= 1'b0;
      y_data     <= '0;
      y_src      <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      last_grant <= last_nx;
      s          <= (state_nx == ST_G1);
      if (acc0 || acc1) begin
        y_valid <= 1'b1;
        y_data  <= mux_data;
        y_src   <= s;
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
// ============================================================================
// tb_mux2_rr_arbiter : randomized bench with an owner/tenure reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux2_rr_arbiter;

  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i0_valid, i1_valid, i0_ready, i1_ready;
  logic [DW-1:0] i0_data, i1_data, y_data;
  logic          y_valid, y_src, y_ready, s;

  mux2_rr_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rst      (rst),
    .i0_valid (i0_valid),
    .i0_data  (i0_data),
    .i0_ready (i0_ready),
    .i1_valid (i1_valid),
    .i1_data  (i1_data),
    .i1_ready (i1_ready),
    .y_valid  (y_valid),
    .y_data   (y_data),
    .y_src    (y_src),
    .y_ready  (y_ready),
    .s        (s)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the mux (-1 = nobody), beats in this tenure,
  // who held the last tenure, and the single output slot.
  int            m_owner;
  int            m_beats;
  int            m_last;
  bit            m_yv;
  int            m_ys;
  logic [DW-1:0] m_yd;

  bit            pv [2];
  logic [DW-1:0] pd [2];
  bit            taken [2];

  function automatic void model_reset();
    m_owner = -1; m_beats = 0; m_last = 1;
    m_yv = 0; m_ys = 0; m_yd = '0;
  endfunction

  task automatic cycle(input int p_valid, input int p_yready, input int p_rst);
    bit free;
    bit rdy [2];
    bit acc [2];
    int k, o, n_owner;
    // Producers keep a beat until it is taken, then maybe offer another.
    for (int i = 0; i < 2; i++) begin
      if (!pv[i] || taken[i]) begin
        pv[i] = ($urandom_range(99) < p_valid);
        pd[i] = DW'($urandom);
      end
    end
    i0_valid = pv[0]; i0_data = pd[0];
    i1_valid = pv[1]; i1_data = pd[1];
    rst      = ($urandom_range(99) < p_rst);
    y_ready  = ($urandom_range(99) < p_yready);
    #2;
    free = !m_yv || y_ready;
    for (int i = 0; i < 2; i++) rdy[i] = (m_owner == i) && free;
    check("i0_ready", 32'(i0_ready), 32'(rdy[0]));
    check("i1_ready", 32'(i1_ready), 32'(rdy[1]));
    check("y_valid",  32'(y_valid),  32'(m_yv));
    check("s",        32'(s),        32'(m_owner == 1));
    if (m_yv) begin
      check("y_src",  32'(y_src),  32'(m_ys));
      check("y_data", 32'(y_data), 32'(m_yd));
    end
    for (int i = 0; i < 2; i++) acc[i] = pv[i] && rdy[i];
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
      taken[0] = 0; taken[1] = 0;
      return;
    end
    taken[0] = acc[0]; taken[1] = acc[1];
    if (acc[0] || acc[1]) begin
      k = acc[0] ? 0 : 1;
      m_yv = 1; m_ys = k; m_yd = pd[k];
    end else if (m_yv && y_ready) begin
      m_yv = 0;
    end
    n_owner = m_owner;
    if (m_owner < 0) begin
      if (pv[0] && pv[1]) n_owner = 1 - m_last;
      else if (pv[0])     n_owner = 0;
      else if (pv[1])     n_owner = 1;
    end else begin
      k = m_owner; o = 1 - k;
      if (!pv[k]) begin
        n_owner = pv[o] ? o : -1;
        m_beats = 0; m_last = k;
      end else if (acc[k]) begin
        m_beats++;
        if (m_beats == MB) begin
          m_beats = 0; m_last = k;
          if (pv[o]) n_owner = o;
        end
      end
    end
    m_owner = n_owner;
  endtask

  initial begin
    rst = 1'b1; y_ready = 1'b0;
    i0_valid = 1'b0; i1_valid = 1'b0; i0_data = '0; i1_data = '0;
    pv[0] = 0; pv[1] = 0; pd[0] = '0; pd[1] = '0; taken[0] = 0; taken[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    // Reset state is checked on the first call.
    cycle(0, 100, 100);
    repeat (200) cycle(100, 100, 0);  // saturated: strict alternating bursts
    repeat (300) cycle(60, 100, 0);   // sparse requests, valid drops
    repeat (300) cycle(70, 40, 0);    // heavy output stalls
    repeat (400) cycle(50, 70, 2);    // mixed with occasional resets
    repeat (400) cycle(90, 85, 1);
    repeat (100) cycle(100, 100, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
